// File: rtl/extbus_responder.sv
// extbus_responder: synchronises the async host bus and turns accesses into single-cycle register strobes
module extbus_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_in,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  output logic [4:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_write,
  output logic [4:0] reg_rd_addr,
  input  logic [7:0] reg_rd_data,
  output logic       reg_read_done,
  output logic [4:0] reg_rd_done_addr
);
  // Packed sample {cs_n, rd_n, wr_n, a[4:0], d[7:0]}; idle value has all strobes inactive.
  localparam logic [15:0] IDLE = 16'hE000;
  logic [15:0] sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld;
  logic wr_act, rd_act, wr_act_q, rd_act_q, armed, wr_fall, rd_fall;
  logic [4:0] wr_hold_a, rd_hold_a;
  logic [7:0] wr_hold_d;
  assign wr_act = !sync[SYNC_STAGES-1][15] && !sync[SYNC_STAGES-1][13];
  assign rd_act = !sync[SYNC_STAGES-1][15] && !sync[SYNC_STAGES-1][14] && !wr_act;
  assign wr_fall = armed && wr_act_q && !wr_act;
  assign rd_fall = armed && rd_act_q && !rd_act;
  assign reg_rd_addr = sync[0][12:8];
  assign extbus_d_oe = !extbus_cs_n && !extbus_rd_n && extbus_wr_n;
  // Shared synchroniser for strobes and payload so they stay cycle-aligned; vld marks real pad samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= IDLE;
      vld <= '0;
    end else begin
      sync[0] <= {extbus_cs_n, extbus_rd_n, extbus_wr_n, extbus_a, extbus_d_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      vld <= {vld[SYNC_STAGES-2:0], 1'b1};
    end
  end
  // Arm only on an idle sample that came from the pads, so an access spanning reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      wr_hold_a <= '0;
      wr_hold_d <= '0;
      rd_hold_a <= '0;
    end else begin
      armed    <= armed || (vld[SYNC_STAGES-1] && !wr_act && !rd_act);
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (wr_act) begin
        wr_hold_a <= sync[SYNC_STAGES-1][12:8];
        wr_hold_d <= sync[SYNC_STAGES-1][7:0];
      end
      if (rd_act) rd_hold_a <= sync[SYNC_STAGES-1][12:8];
    end
  end
  // One-cycle completion strobes on the falling edge of each active condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write        <= 1'b0;
      reg_wr_addr      <= '0;
      reg_wr_data      <= '0;
      reg_read_done    <= 1'b0;
      reg_rd_done_addr <= '0;
    end else begin
      reg_write     <= wr_fall;
      reg_read_done <= rd_fall;
      if (wr_fall) begin
        reg_wr_addr <= wr_hold_a;
        reg_wr_data <= wr_hold_d;
      end
      if (rd_fall) reg_rd_done_addr <= rd_hold_a;
    end
  end
  // Track register-file read data while the first-stage sample shows a read in progress.
  always_ff @(posedge clk) begin
    if (rst) extbus_d_out <= '0;
    else if (!sync[0][15] && !sync[0][14]) extbus_d_out <= reg_rd_data;
  end
endmodule

// File: tb/tb_extbus_responder.sv
// tb_extbus_responder: randomized host-bus stimulus checked against a queue-based transaction model
module tb_extbus_responder;
  localparam int SYNC = 2;
  logic clk = 0, rst = 1;
  logic cs_n = 1, rd_n = 1, wr_n = 1;
  logic [4:0] a = 0;
  logic [7:0] din = 0;
  logic [7:0] d_out, wr_data, rd_data;
  logic d_oe, write, read_done;
  logic [4:0] wr_addr, rd_addr, done_addr;
  logic [7:0] mem [32];
  int checks = 0, failures = 0, cyc = 0;
  logic [12:0] exp_wr[$], got_wr[$];
  int exp_cyc[$], got_cyc[$];
  logic [4:0] exp_rd[$], got_rd[$];

  extbus_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .extbus_cs_n(cs_n), .extbus_rd_n(rd_n), .extbus_wr_n(wr_n),
    .extbus_a(a), .extbus_d_in(din), .extbus_d_out(d_out), .extbus_d_oe(d_oe),
    .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_write(write),
    .reg_rd_addr(rd_addr), .reg_rd_data(rd_data), .reg_read_done(read_done),
    .reg_rd_done_addr(done_addr));

  assign rd_data = mem[rd_addr];
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (write) begin
      got_wr.push_back({wr_addr, wr_data});
      got_cyc.push_back(cyc);
    end
    if (read_done) got_rd.push_back(done_addr);
  end

  task automatic clear_queues();
    exp_wr.delete(); got_wr.delete(); exp_cyc.delete(); got_cyc.delete();
    exp_rd.delete(); got_rd.delete();
  endtask

  task automatic bus_write(input logic [4:0] ad, input logic [7:0] dd, input int w, input int gap);
    @(posedge clk); #7;
    a = ad; din = dd; cs_n = 0; wr_n = 0;
    repeat (w) @(posedge clk);
    #7 wr_n = 1;
    exp_wr.push_back({ad, dd});
    exp_cyc.push_back(cyc);
    #5 cs_n = 1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic bus_read(input logic [4:0] ad, input int w, input int gap);
    @(posedge clk); #7;
    a = ad; cs_n = 0; rd_n = 0;
    #1 checks++;
    if (d_oe !== 1'b1) begin failures++; $display("FAIL rd_oe_on actual=%b required=1", d_oe); end
    repeat (w) @(posedge clk);
    #7 checks++;
    if (d_out !== mem[ad]) begin failures++; $display("FAIL rd_data addr=%h actual=%h required=%h", ad, d_out, mem[ad]); end
    rd_n = 1;
    exp_rd.push_back(ad);
    #1 checks++;
    if (d_oe !== 1'b0) begin failures++; $display("FAIL rd_oe_off actual=%b required=0", d_oe); end
    #4 cs_n = 1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (write !== 0) begin failures++; $display("FAIL rst_write actual=%b required=0", write); end
    if (read_done !== 0) begin failures++; $display("FAIL rst_read_done actual=%b required=0", read_done); end
    if (d_out !== 8'h00) begin failures++; $display("FAIL rst_d_out actual=%h required=00", d_out); end
    if (wr_addr !== 5'h0 || wr_data !== 8'h0) begin failures++; $display("FAIL rst_wr_payload actual=%h/%h required=0/0", wr_addr, wr_data); end
    if (done_addr !== 5'h0) begin failures++; $display("FAIL rst_done_addr actual=%h required=0", done_addr); end
    if (rd_addr !== 5'h0) begin failures++; $display("FAIL rst_rd_addr actual=%h required=0", rd_addr); end
    if (d_oe !== 0) begin failures++; $display("FAIL rst_oe actual=%b required=0", d_oe); end
    rst = 0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single_write();
    clear_queues();
    bus_write(5'h05, 8'h01, 3, 6);
    checks++;
    if (got_wr.size() != 1) begin failures++; $display("FAIL single_count actual=%0d required=1", got_wr.size()); end
    else begin
      checks += 2;
      if (got_wr[0] !== {5'h05, 8'h01}) begin failures++; $display("FAIL single_payload actual=%h required=%h", got_wr[0], {5'h05, 8'h01}); end
      if (got_cyc[0] - exp_cyc[0] != SYNC + 1) begin failures++; $display("FAIL single_latency actual=%0d required=%0d", got_cyc[0] - exp_cyc[0], SYNC + 1); end
    end
  endtask

  task automatic test_write_sequence();
    logic [4:0] la [7] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd4, 5'd4, 5'd4};
    logic [7:0] ld [7] = '{8'h00, 8'h40, 8'h10, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    clear_queues();
    for (int i = 0; i < 7; i++) bus_write(la[i], ld[i], 2 + i % 2, 2);
    for (int i = 0; i < 20; i++) bus_write(5'($urandom), 8'($urandom), $urandom_range(2, 5), $urandom_range(1, 4));
    repeat (6) @(posedge clk);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL seq_count actual=%0d required=%0d", got_wr.size(), exp_wr.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      checks += 2;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL seq_payload idx=%0d actual=%h required=%h", i, got_wr[i], exp_wr[i]); end
      if (got_cyc[i] - exp_cyc[i] != SYNC + 1) begin failures++; $display("FAIL seq_latency idx=%0d actual=%0d required=%0d", i, got_cyc[i] - exp_cyc[i], SYNC + 1); end
    end
    checks++;
    if (got_rd.size() != 0) begin failures++; $display("FAIL seq_spurious_read actual=%0d required=0", got_rd.size()); end
  endtask

  task automatic test_read();
    clear_queues();
    mem[4] = 8'hA1;
    bus_read(5'h04, 3, 3);
    for (int i = 0; i < 12; i++) bus_read(5'($urandom), $urandom_range(3, 5), $urandom_range(1, 3));
    repeat (6) @(posedge clk);
    checks++;
    if (got_rd.size() != exp_rd.size()) begin failures++; $display("FAIL read_count actual=%0d required=%0d", got_rd.size(), exp_rd.size()); end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      checks++;
      if (got_rd[i] !== exp_rd[i]) begin failures++; $display("FAIL read_done_addr idx=%0d actual=%h required=%h", i, got_rd[i], exp_rd[i]); end
    end
    checks++;
    if (got_wr.size() != 0) begin failures++; $display("FAIL read_spurious_write actual=%0d required=0", got_wr.size()); end
  endtask

  task automatic test_rd_wr_both();
    clear_queues();
    @(posedge clk); #7;
    a = 5'h03; din = 8'h5A; cs_n = 0; rd_n = 0; wr_n = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (d_oe !== 1'b0) begin failures++; $display("FAIL both_oe actual=%b required=0", d_oe); end
    #6 rd_n = 1; wr_n = 1;
    #5 cs_n = 1;
    repeat (6) @(posedge clk);
    checks += 2;
    if (got_wr.size() != 1 || got_wr[0] !== {5'h03, 8'h5A}) begin failures++; $display("FAIL both_write count=%0d required=1 of %h", got_wr.size(), {5'h03, 8'h5A}); end
    if (got_rd.size() != 0) begin failures++; $display("FAIL both_read_done actual=%0d required=0", got_rd.size()); end
  endtask

  task automatic test_reset_mid_access();
    clear_queues();
    @(posedge clk); #7;
    a = 5'h09; din = 8'h33; cs_n = 0; wr_n = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    repeat (3) @(posedge clk);
    #7 wr_n = 1;
    #5 cs_n = 1;
    repeat (6) @(posedge clk);
    checks++;
    if (got_wr.size() != 0) begin failures++; $display("FAIL midrst_suppress actual=%0d required=0", got_wr.size()); end
    clear_queues();
    bus_write(5'h02, 8'h7E, 3, 6);
    checks++;
    if (got_wr.size() != 1 || got_wr[0] !== {5'h02, 8'h7E}) begin failures++; $display("FAIL midrst_next count=%0d required=1 of %h", got_wr.size(), {5'h02, 8'h7E}); end
  endtask

  task automatic test_no_cs();
    int bad = 0;
    clear_queues();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #7;
      a = 5'($urandom); din = 8'($urandom);
      wr_n = i[0]; rd_n = i[1];
      #1 if (d_oe !== 1'b0) bad++;
    end
    wr_n = 1; rd_n = 1;
    repeat (6) @(posedge clk);
    checks += 3;
    if (bad != 0) begin failures++; $display("FAIL nocs_oe actual=%0d required=0", bad); end
    if (got_wr.size() != 0) begin failures++; $display("FAIL nocs_write actual=%0d required=0", got_wr.size()); end
    if (got_rd.size() != 0) begin failures++; $display("FAIL nocs_read actual=%0d required=0", got_rd.size()); end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1)) bus_write(5'($urandom), 8'($urandom), 2, 1);
      else bus_read(5'($urandom), 3, 1);
    end
    repeat (6) @(posedge clk);
    checks += 2;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL b2b_wr_count actual=%0d required=%0d", got_wr.size(), exp_wr.size()); end
    if (got_rd.size() != exp_rd.size()) begin failures++; $display("FAIL b2b_rd_count actual=%0d required=%0d", got_rd.size(), exp_rd.size()); end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL b2b_wr idx=%0d actual=%h required=%h", i, got_wr[i], exp_wr[i]); end
    end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      checks++;
      if (got_rd[i] !== exp_rd[i]) begin failures++; $display("FAIL b2b_rd idx=%0d actual=%h required=%h", i, got_rd[i], exp_rd[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single_write();
    test_write_sequence();
    test_read();
    test_rd_wr_both();
    test_reset_mid_access();
    test_no_cs();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/extbus_responder.md
Name: extbus_responder

Overview:
- FPGA-side responder for the asynchronous 6502-style external bus: extbus_cs_n, extbus_rd_n, extbus_wr_n, extbus_a[4:0] and extbus_d.
- Synchronises the bus strobes into the clk domain and converts each bus write into a single-cycle register write strobe.
- Serves bus reads from a combinational register-file read port, then emits a single-cycle read-completion strobe so the register file can apply read side effects (DATA0/DATA1 auto-increment).
- Sits between the top-level pads and the register file.

Parameters:
- SYNC_STAGES, 2, number of flops in the strobe/address/data synchroniser pipeline (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- extbus_cs_n  input  1  bus chip select, async, active low
- extbus_rd_n  input  1  read strobe, async, active low
- extbus_wr_n  input  1  write strobe, async, active low
- extbus_a  input  5  register address, async
- extbus_d_in  input  8  bus data from host
- extbus_d_out  output  8  bus data to host
- extbus_d_oe  output  1  bus data output enable
- reg_wr_addr  output  5  address of the current write
- reg_wr_data  output  8  data of the current write
- reg_write  output  1  one-cycle write strobe
- reg_rd_addr  output  5  read address presented to the register file
- reg_rd_data  input  8  combinational read data for reg_rd_addr
- reg_read_done  output  1  one-cycle strobe at the end of a read access
- reg_rd_done_addr  output  5  address of the read that just completed

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: all pipeline strobes inactive (1), address/data stages 0, reg_write=0, reg_read_done=0, extbus_d_out=0x00, addr/data outputs 0, armed=0.
- Synchronisation: cs_n, rd_n, wr_n, a and d_in are all sampled through the same SYNC_STAGES pipeline, so strobes and payload stay cycle-aligned.
- Active conditions, evaluated at the last stage: wr_act = !cs && !wr; rd_act = !cs && !rd && !wr_act.
  - Write has priority; simultaneous rd and wr is treated as a write only.
- Arming: armed sets on the first post-reset cycle where both wr_act and rd_act are 0.
  - Edges are ignored while armed=0, so an access already in flight at reset release produces no strobe.
- Write path:
  - Every cycle wr_act=1, the hold registers capture the last-stage a and d_in.
  - On the first cycle wr_act falls 1->0 (armed): reg_write=1 for exactly 1 cycle, with reg_wr_addr/reg_wr_data = hold registers, i.e. the last sample taken while the strobe was low.
  - Write pulse latency: SYNC_STAGES+1 clk after the raw strobe rises.
- Read path:
  - reg_rd_addr = first synchroniser stage of extbus_a, updated every clk.
  - While stage-1 rd/cs are active, extbus_d_out <= reg_rd_data every clk. Otherwise extbus_d_out holds its value.
  - Address-to-data latency: 2 clk.
  - extbus_d_oe = !extbus_cs_n && !extbus_rd_n && extbus_wr_n. This is combinational from the raw pads so the bus is driven without sync delay.
  - On the rd_act 1->0 transition (armed): reg_read_done=1 for 1 cycle, and reg_rd_done_addr = the address last sampled while rd_act was 1.
- Back-to-back accesses: each strobe-inactive gap of at least 1 sampled clk produces a separate pulse.
  - A strobe low for fewer clocks than sampling resolution may be missed. This is legal only if the host violates its minimum strobe width (≥1.5 clk).
- cs_n deasserting before wr_n ends the access: the falling edge of wr_act fires the write using the held data.
- Reset mid-access: all strobes are suppressed; no partial pulses are emitted after rst deasserts until re-armed.
- No pulses are emitted while rst=1.

Test Plan:
- Write addr 0x05 data 0x01 (8 MHz phi2, 25 MHz clk) -> exactly one reg_write with reg_wr_addr=0x05, reg_wr_data=0x01, within SYNC_STAGES+1 clk of wr_n rise.
- Writes 0x00/0x40/0x10 to addrs 0/1/2, then four writes A1..A4 to addr 4 -> seven reg_write pulses in order, with exact addr/data; no extra pulses.
- Read addr 4 with reg_rd_data model returning 0xA1 -> extbus_d_oe high only while cs/rd low; extbus_d_out=0xA1 before the rd_n rise; one reg_read_done with reg_rd_done_addr=0x04.
- rd_n and wr_n both low with addr 0x03, data 0x5A -> one reg_write(0x03,0x5A); no reg_read_done; extbus_d_oe=0.
- Assert rst while wr_n is low, release mid-strobe -> no reg_write for that access; the next full write 0x02→0x7E is captured normally.
- cs_n high, wr_n toggled -> no strobes; extbus_d_oe=0 throughout.
